// File: rtl/simpson_param_entry_if.sv
// Click/handshake bundle between the debouncer bank, the parameter-entry
// controller and the Simpson's-rule core.
interface simpson_param_entry_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N_WIDTH    = 6
);
  logic                         ce;
  logic                         up_click;
  logic                         down_click;
  logic                         next_click;
  logic                         start_click;
  logic                         core_done;
  logic signed [DATA_WIDTH-1:0] a;
  logic signed [DATA_WIDTH-1:0] b;
  logic        [N_WIDTH-1:0]    n;
  logic        [1:0]            field_sel;
  logic                         start;
  logic                         busy;
  logic                         err;

  modport master (
    output ce, up_click, down_click, next_click, start_click, core_done,
    input  a, b, n, field_sel, start, busy, err
  );

  modport slave (
    input  ce, up_click, down_click, next_click, start_click, core_done,
    output a, b, n, field_sel, start, busy, err
  );
endinterface

// File: rtl/simpson_param_entry.sv
// Edit/launch controller: turns debounced clicks into saturated a/b/n
// parameters and launches the Simpson's-rule core once a < b holds.
module simpson_param_entry #(
  parameter int DATA_WIDTH = 8,
  parameter int N_WIDTH    = 6,
  parameter int A_INIT     = 0,
  parameter int B_INIT     = 8,
  parameter int N_INIT     = 4,
  parameter int N_MAX      = 32
) (
  input logic                  clk,
  input logic                  rst,
  simpson_param_entry_if.slave bus
);

  typedef enum logic [1:0] {ST_EDIT, ST_CHECK, ST_LAUNCH, ST_WAIT} state_t;

  localparam logic signed [DATA_WIDTH-1:0] S_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] S_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] S_ONE = DATA_WIDTH'(1);
  localparam logic [N_WIDTH-1:0]           N_HI  = N_WIDTH'(N_MAX);
  localparam logic [N_WIDTH-1:0]           N_LO  = N_WIDTH'(2);

  function automatic logic signed [DATA_WIDTH-1:0] sat_step_s(
    input logic signed [DATA_WIDTH-1:0] x, input logic dec);
    if (dec) return (x == S_MIN) ? x : x - S_ONE;
    else     return (x == S_MAX) ? x : x + S_ONE;
  endfunction

  function automatic logic [N_WIDTH-1:0] sat_step_n(
    input logic [N_WIDTH-1:0] x, input logic dec);
    if (dec) return (x <= N_LO) ? N_LO : x - N_WIDTH'(2);
    else     return (x >= N_HI) ? N_HI : x + N_WIDTH'(2);
  endfunction

  state_t                       state_q, state_d;
  logic signed [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic        [N_WIDTH-1:0]    n_q, n_d;
  logic        [1:0]            field_sel_q, field_sel_d;
  logic                         start_q, start_d, busy_q, busy_d, err_q, err_d;

  // One action per ce tick in EDIT, priority start > next > up > down.
  logic edit_tick, do_start, do_next, do_up, do_down, a_lt_b;
  assign edit_tick = (state_q == ST_EDIT) && bus.ce;
  assign do_start  = edit_tick && bus.start_click;
  assign do_next   = edit_tick && !bus.start_click && bus.next_click;
  assign do_up     = edit_tick && !bus.start_click && !bus.next_click && bus.up_click;
  assign do_down   = edit_tick && !bus.start_click && !bus.next_click && !bus.up_click
                     && bus.down_click;
  assign a_lt_b    = a_q < b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EDIT;
      a_q         <= DATA_WIDTH'(A_INIT);
      b_q         <= DATA_WIDTH'(B_INIT);
      n_q         <= N_WIDTH'(N_INIT);
      field_sel_q <= 2'd0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      n_q         <= n_d;
      field_sel_q <= field_sel_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EDIT:   if (do_start) state_d = ST_CHECK;
      ST_CHECK:  state_d = a_lt_b ? ST_LAUNCH : ST_EDIT;
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT:   if (bus.core_done) state_d = ST_EDIT;
      default:   state_d = ST_EDIT;
    endcase
  end

  // Registered outputs: start/busy are loaded on the CHECK->LAUNCH edge so
  // they are visible exactly while the state register holds LAUNCH.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    n_d         = n_q;
    field_sel_d = field_sel_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    err_d       = err_q;
    if (do_next) begin
      field_sel_d = (field_sel_q == 2'd2) ? 2'd0 : field_sel_q + 2'd1;
      err_d       = 1'b0;
    end
    if (do_up || do_down) begin
      err_d = 1'b0;
      case (field_sel_q)
        2'd0:    a_d = sat_step_s(a_q, do_down);
        2'd1:    b_d = sat_step_s(b_q, do_down);
        default: n_d = sat_step_n(n_q, do_down);
      endcase
    end
    if (state_q == ST_CHECK) begin
      if (a_lt_b) begin
        err_d   = 1'b0;
        start_d = 1'b1;
        busy_d  = 1'b1;
      end else begin
        err_d       = 1'b1;
        field_sel_d = 2'd0;
      end
    end
    if (state_q == ST_WAIT && bus.core_done) busy_d = 1'b0;
  end

  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.n         = n_q;
  assign bus.field_sel = field_sel_q;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_simpson_param_entry.sv
// Directed bench for simpson_param_entry: reset, saturation, priority,
// launch accept/reject and reset during an outstanding computation.
module tb_simpson_param_entry;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   start_cnt = 0;

  always #5 clk = ~clk;

  simpson_param_entry_if #(.DATA_WIDTH(8), .N_WIDTH(6)) bus ();

  simpson_param_entry #(
    .DATA_WIDTH(8), .N_WIDTH(6), .A_INIT(0), .B_INIT(8), .N_INIT(4), .N_MAX(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(negedge clk) if (bus.start === 1'b1) start_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic press(input logic u, input logic d, input logic nx, input logic st);
    bus.ce = 1'b1;
    bus.up_click = u; bus.down_click = d; bus.next_click = nx; bus.start_click = st;
    tick();
    bus.up_click = 1'b0; bus.down_click = 1'b0; bus.next_click = 1'b0; bus.start_click = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".a"}, bus.a, 0);
    chk({tag, ".b"}, bus.b, 8);
    chk({tag, ".n"}, bus.n, 4);
    chk({tag, ".field_sel"}, bus.field_sel, 0);
    chk({tag, ".start"}, bus.start, 0);
    chk({tag, ".busy"}, bus.busy, 0);
    chk({tag, ".err"}, bus.err, 0);
  endtask

  initial begin
    bus.ce = 1'b0; bus.up_click = 1'b0; bus.down_click = 1'b0;
    bus.next_click = 1'b0; bus.start_click = 1'b0; bus.core_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("reset");

    // Idle with ce running, then clicks held while ce is low.
    for (int i = 0; i < 100; i++) begin bus.ce = (i % 4 == 0); tick(); end
    chk_reset_vals("idle");
    chk("idle.start_cnt", start_cnt, 0);
    bus.ce = 1'b0; bus.up_click = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("ce_low.a", bus.a, 0);
    // up held for 12 clocks, ce high on 3 of them: exactly 3 increments
    for (int i = 0; i < 12; i++) begin bus.ce = (i % 4 == 0); tick(); end
    bus.up_click = 1'b0; bus.ce = 1'b0;
    chk("ce_period.a", bus.a, 3);
    for (int i = 0; i < 3; i++) press(0, 1, 0, 0);
    chk("down3.a", bus.a, 0);

    // next wins over up on the same tick
    press(1, 0, 1, 0);
    chk("prio.field_sel", bus.field_sel, 1);
    chk("prio.a", bus.a, 0);

    for (int i = 0; i < 200; i++) press(1, 0, 0, 0);
    chk("sat_b_max", bus.b, 127);
    for (int i = 0; i < 119; i++) press(0, 1, 0, 0);
    chk("b_back", bus.b, 8);

    press(0, 0, 1, 0);
    chk("sel_n", bus.field_sel, 2);
    for (int i = 0; i < 20; i++) press(1, 0, 0, 0);
    chk("sat_n_max", bus.n, 32);
    for (int i = 0; i < 20; i++) press(0, 1, 0, 0);
    chk("sat_n_min", bus.n, 2);
    press(1, 0, 0, 0);
    chk("n_up", bus.n, 4);

    press(0, 0, 1, 0);
    chk("wrap0", bus.field_sel, 0);
    press(0, 0, 1, 0);
    chk("wrap1", bus.field_sel, 1);
    press(0, 0, 1, 0);
    chk("wrap2", bus.field_sel, 2);
    press(0, 0, 1, 0);
    chk("wrap3", bus.field_sel, 0);

    for (int i = 0; i < 200; i++) press(0, 1, 0, 0);
    chk("sat_a_min", bus.a, -128);
    for (int i = 0; i < 128; i++) press(1, 0, 0, 0);
    chk("a_back", bus.a, 0);

    // Valid launch: a=0 < b=8, start click at edge T
    start_cnt = 0;
    press(0, 0, 0, 1);
    chk("launch.T1.start", bus.start, 0);
    chk("launch.T1.busy", bus.busy, 0);
    tick();
    chk("launch.T2.start", bus.start, 1);
    chk("launch.T2.busy", bus.busy, 1);
    tick();
    chk("launch.T3.start", bus.start, 0);
    chk("launch.T3.busy", bus.busy, 1);
    for (int i = 0; i < 10; i++) press(i % 2 == 0, 0, i % 3 == 0, i % 5 == 0);
    chk("wait.a", bus.a, 0);
    chk("wait.field_sel", bus.field_sel, 0);
    chk("wait.busy", bus.busy, 1);
    chk("wait.start_cnt", start_cnt, 1);
    bus.core_done = 1'b1;
    press(1, 0, 0, 0);
    bus.core_done = 1'b0;
    chk("done.busy", bus.busy, 0);
    chk("done.a", bus.a, 0);
    press(1, 0, 0, 0);
    chk("edit_again.a", bus.a, 1);

    // Invalid launch: a=5, b=5; start+next together, start wins
    for (int i = 0; i < 4; i++) press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) press(0, 1, 0, 0);
    chk("inv.a", bus.a, 5);
    chk("inv.b", bus.b, 5);
    start_cnt = 0;
    press(0, 0, 1, 1);
    chk("inv.check.field_sel", bus.field_sel, 1);
    tick();
    chk("inv.err", bus.err, 1);
    chk("inv.field_sel", bus.field_sel, 0);
    chk("inv.busy", bus.busy, 0);
    tick(); tick();
    chk("inv.start_cnt", start_cnt, 0);
    chk("inv.err_held", bus.err, 1);
    press(1, 0, 0, 0);
    chk("inv.fix.a", bus.a, 6);
    chk("inv.fix.err", bus.err, 0);

    // Reset while waiting on the core
    press(0, 0, 1, 0);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    chk("rw.b", bus.b, 7);
    press(0, 0, 0, 1);
    tick(); tick();
    chk("rw.busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_vals("rst_wait");
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    tick();
    chk_reset_vals("late_done");

    // Reset on the edge that would enter LAUNCH: no start pulse
    start_cnt = 0;
    press(0, 0, 0, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_launch.start_cnt", start_cnt, 0);
    chk("rst_launch.busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/simpson_param_entry.md
# simpson_param_entry

Parameter-entry controller that consumes the single-tick click pulses produced by the button debouncers and turns them into the integration parameters (lower bound a, upper bound b, step count n) for the Simpson's-rule core. It runs a small edit/launch state machine, saturates every edit, validates a < b before launch, and handshakes with the core via a one-cycle start strobe and a done pulse. It sits between the debouncer bank and the computation core.

## Interface
- DATA_WIDTH, 8: width of signed bounds a and b (two's complement).
- N_WIDTH, 6: width of unsigned step count n.
- A_INIT, 0: reset value of a.
- B_INIT, 8: reset value of b.
- N_INIT, 4: reset value of n; must be even and within [2, N_MAX].
- N_MAX, 32: largest allowed n; must be even and ≤ 2^N_WIDTH − 2.
- clk  in  1  single system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  clock enable shared with the debouncers; click inputs are sampled only when ce=1.
- up_click  in  1  debounced click: increment selected field.
- down_click  in  1  debounced click: decrement selected field.
- next_click  in  1  debounced click: advance field selection.
- start_click  in  1  debounced click: request launch.
- core_done  in  1  one-cycle pulse from core, computation finished.
- a  out  DATA_WIDTH  lower bound, signed.
- b  out  DATA_WIDTH  upper bound, signed.
- n  out  N_WIDTH  step count, even.
- field_sel  out  2  selected field: 0=a, 1=b, 2=n.
- start  out  1  one-clk launch strobe to core.
- busy  out  1  high while core computation is outstanding.
- err  out  1  last launch rejected (a ≥ b).

## Operation
- Reset values: a=A_INIT, b=B_INIT, n=N_INIT, field_sel=0, start=0, busy=0, err=0, state=EDIT.
- States: EDIT, CHECK, LAUNCH, WAIT. All outputs registered.
- EDIT: clicks act only on a clk edge with ce=1. Priority when several clicks coincide: start > next > up > down; exactly one action per ce tick, the others dropped.
  - up/down on a or b: ±1, saturating at signed min/max of DATA_WIDTH.
  - up/down on n: ±2, saturating at 2 and N_MAX.
  - next: field_sel 0→1→2→0 (wraps).
  - any accepted up/down/next clears err.
  - start: → CHECK.
- CHECK (one clk, ce ignored): if signed a < b → LAUNCH, err=0; else → EDIT, err=1, field_sel=0.
- LAUNCH (one clk): start=1, busy=1, → WAIT.
- WAIT: all clicks ignored, parameters frozen; on core_done=1 → EDIT, busy=0 next cycle. core_done outside WAIT is ignored.
- rst in any state, including WAIT or LAUNCH, returns every register to reset values on that edge; start never asserts in the reset cycle.

## Timing
- Edit latency: click with ce=1 at edge T → updated a/b/n/field_sel visible after T.
- Launch: start_click at ce edge T → CHECK during cycle T+1 → start=1 and busy=1 during cycle T+2 only → WAIT from T+3.
- start is exactly one clk wide regardless of ce.
- core_done at edge D (in WAIT) → busy=0, state EDIT after D; a click on the same edge D is ignored.
- Rejected launch: err=1 from cycle T+2, held until next accepted edit or reset.
- Click inputs held high for a whole ce period are counted once per ce=1 edge, never per clk.

## Test plan
- Reset then idle: rst 1 cycle → a=0, b=8, n=4, field_sel=0, start=0, busy=0, err=0; no change over 100 cycles without clicks.
- Saturation: select b, 200 up clicks at DATA_WIDTH=8 → b=127; select n, 20 up → n=32; 20 down → n=2.
- Priority/wrap: next+up on the same ce tick → field_sel advances 0→1, a unchanged; three nexts from 0 → 0.
- Valid launch: a=0, b=8, start_click at T → start high exactly in cycle T+2, busy high T+2 until core_done, 10 clicks during WAIT have no effect.
- Invalid launch: a=5, b=5, start → no start pulse, err=1, field_sel=0; one up click → a=6, err=0.
- Reset mid-WAIT: rst while busy=1 → all outputs at reset values next cycle; a later core_done pulse causes no change.
